cache_state_update: RTL and testbench
=====================================

# cache_state_update

Write side of the 4-way set-associative L1 tag-state array: holds per-set valid, modified and 3-bit tree-PLRU state, serves the registered state read consumed by the tag compare/victim-select logic, and applies hit, fill and invalidate updates with write-forwarding. It also runs a sequential flush sweep that clears every set. It sits between the cache controller FSM, which issues updates and flushes, and the compare stage, which reads `lru_output_d`, `val_output_d` and `mod_output_d`.

## Interface
- SETS, 256, number of sets; power of two, 2..4096
- IDX_W, 8, set index width; must equal log2(SETS)

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- rd_valid  in  1  state read request
- rd_idx  in  IDX_W  set to read
- lru_output_d  out  3  PLRU bits of the read set, registered
- val_output_d  out  4  valid bits, bit n = way n, registered
- mod_output_d  out  4  modified bits, registered
- upd_valid  in  1  update request, accepted only when upd_ready=1
- upd_ready  out  1  equals !flush_busy
- upd_idx  in  IDX_W  set to update
- upd_way  in  4  target way, must be one-hot
- upd_op  in  2  00 read hit, 01 write hit, 10 fill, 11 invalidate
- upd_dirty  in  1  fill only: mod value written to the filled way
- upd_err  out  1  one-cycle pulse when an update is accepted with a non-one-hot upd_way
- flush_req  in  1  start flush sweep; ignored while busy
- flush_busy  out  1  sweep in progress
- flush_done  out  1  one-cycle pulse when the sweep completes

## Operation
- **State per set:** lru[2:0], val[3:0], mod[3:0]. The whole array is flops and is reset to 0.
- **PLRU encoding** (victim selection = decode of lru): bit2=0 selects the way3/way2 half; bit1 then picks way3 (0) or way2 (1). bit2=1 selects the way1/way0 half; bit0 then picks way1 (0) or way0 (1).
- **Touch rule** (point the tree away from the accessed way):
  - way3: bit2←1, bit1←1
  - way2: bit2←1, bit1←0
  - way1: bit2←0, bit0←1
  - way0: bit2←0, bit0←0
  - Bits not listed are unchanged.
- **upd_op 00 (read hit):** touch.
- **upd_op 01 (write hit):** touch; mod[w]←1.
- **upd_op 10 (fill):** val[w]←1; mod[w]←upd_dirty; touch.
- **upd_op 11 (invalidate):** val[w]←0; mod[w]←0; lru unchanged.
- **Non-one-hot upd_way** (including 0): no state change; upd_err pulses.
- **Flush FSM, IDLE:**
  - flush_req=1 moves to SWEEP with counter←0.
  - If flush_req and upd_valid arrive in the same cycle, the update is applied first, then the sweep starts.
- **Flush FSM, SWEEP:**
  - Each cycle, set[counter] ← lru 0, val 0, mod 0, then counter increments.
  - After the set at index SETS-1 is cleared, return to IDLE and pulse flush_done for one cycle.
  - Updates are not accepted (upd_ready=0).
  - Reads are still served and return current array contents; sets already cleared read as 0.
- **Reset mid-sweep:** aborts to IDLE, with the array and all outputs at 0. flush_done does not pulse.

## Timing
- Read latency is 1 cycle. rd_idx sampled at edge N appears on the outputs after edge N, which is the compare-stage cycle.
- Outputs hold their last value when rd_valid=0.
- An update is written at the edge where upd_valid && upd_ready.
- Write-forwarding: a read and an accepted update to the same set at the same edge return the post-update state. Reads of that set at later edges also see it.
- Same-edge read of the set being cleared by the sweep returns zeros.
- Flush timing: flush_busy rises the cycle after flush_req is sampled and stays high for exactly SETS cycles. flush_done is asserted in the cycle after the last clear; flush_busy is low in that same cycle.
- Reset values: lru_output_d, val_output_d, mod_output_d = 0; flush_busy=0, flush_done=0, upd_err=0; upd_ready=1.

## Test plan
- **Reset then read:** reset, then read set 5 → lru=000, val=0000, mod=0000; upd_ready=1.
- **Fills and touch sequence:** on set 3 fill way3 (dirty 0), then way2 (dirty 1), way1, way0; after each fill read set 3. Required results, in order:
  - lru 110 / 100 / 001 / 000
  - val 1000 / 1100 / 1110 / 1111
  - mod 0000 / 0100 / 0100 / 0100
- **Write hit, invalidate and bad way** on the resulting set 3:
  - Write hit way1 → mod=0110, lru=001.
  - Invalidate way2 → val=1011, mod=0010, lru=001.
  - Update with upd_way=0110 → upd_err pulses once; state unchanged.
- **Forwarding:** same edge, fill way0 of set 9 (dirty 1) and read set 9 → next cycle val=0001, mod=0001, lru=000.
- **Flush, SETS=8:**
  - Populate all sets, then pulse flush_req → flush_busy high for exactly 8 cycles; upd_valid is ignored throughout; flush_done pulses once; every set then reads 0.
  - Repeat, asserting reset in the 4th sweep cycle → busy drops immediately, no flush_done, all sets read 0.

Source files
------------

// File: rtl/cache_state_update.sv
// Tag-state array for a 4-way set-associative L1: per-set valid, modified and
// tree-PLRU bits. Serves a registered 1-cycle read with write-forwarding,
// applies hit/fill/invalidate updates, and runs a one-set-per-cycle flush sweep.
module cache_state_update #(
    parameter int unsigned SETS  = 256,
    parameter int unsigned IDX_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rd_valid,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [2:0]       lru_output_d,
    output logic [3:0]       val_output_d,
    output logic [3:0]       mod_output_d,
    input  logic             upd_valid,
    output logic             upd_ready,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic [3:0]       upd_way,
    input  logic [1:0]       upd_op,
    input  logic             upd_dirty,
    output logic             upd_err,
    input  logic             flush_req,
    output logic             flush_busy,
    output logic             flush_done
);

    localparam logic [1:0] OP_RD_HIT = 2'b00;
    localparam logic [1:0] OP_WR_HIT = 2'b01;
    localparam logic [1:0] OP_FILL   = 2'b10;
    localparam logic [1:0] OP_INVAL  = 2'b11;

    typedef enum logic {
        ST_IDLE,
        ST_SWEEP
    } state_t;

    // State array
    logic [2:0] lru_q [SETS];
    logic [3:0] val_q [SETS];
    logic [3:0] mod_q [SETS];

    // Flush FSM and registered outputs
    state_t           state_q;
    logic [IDX_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    // Read port registers
    logic [2:0] rd_lru_q;
    logic [3:0] rd_val_q;
    logic [3:0] rd_mod_q;

    // Post-update contents of the addressed set
    logic       way_onehot;
    logic       upd_fire;
    logic       upd_write;
    logic       sweep_active;
    logic [2:0] cur_lru;
    logic [3:0] cur_val;
    logic [3:0] cur_mod;
    logic [2:0] touched_lru;
    logic [2:0] upd_lru_d;
    logic [3:0] upd_val_d;
    logic [3:0] upd_mod_d;

    // Point the PLRU tree away from the accessed way; non-one-hot leaves it unchanged
    function automatic logic [2:0] plru_touch(input logic [2:0] lru, input logic [3:0] way);
        logic [2:0] res;
        res = lru;
        case (way)
            4'b1000: res = {1'b1, 1'b1, lru[0]};
            4'b0100: res = {1'b1, 1'b0, lru[0]};
            4'b0010: res = {1'b0, lru[1], 1'b1};
            4'b0001: res = {1'b0, lru[1], 1'b0};
            default: res = lru;
        endcase
        return res;
    endfunction

    // Update acceptance and next contents of the target set
    always_comb begin
        way_onehot   = (upd_way != 4'd0) && ((upd_way & (upd_way - 4'd1)) == 4'd0);
        upd_fire     = upd_valid && !busy_q;
        upd_write    = upd_fire && way_onehot;
        sweep_active = (state_q == ST_SWEEP);
        cur_lru      = lru_q[upd_idx];
        cur_val      = val_q[upd_idx];
        cur_mod      = mod_q[upd_idx];
        touched_lru  = plru_touch(cur_lru, upd_way);
        upd_lru_d    = cur_lru;
        upd_val_d    = cur_val;
        upd_mod_d    = cur_mod;
        case (upd_op)
            OP_RD_HIT: begin
                upd_lru_d = touched_lru;
            end
            OP_WR_HIT: begin
                upd_lru_d = touched_lru;
                upd_mod_d = cur_mod | upd_way;
            end
            OP_FILL: begin
                upd_lru_d = touched_lru;
                upd_val_d = cur_val | upd_way;
                upd_mod_d = upd_dirty ? (cur_mod | upd_way) : (cur_mod & ~upd_way);
            end
            OP_INVAL: begin
                upd_val_d = cur_val & ~upd_way;
                upd_mod_d = cur_mod & ~upd_way;
            end
            default: begin
                upd_lru_d = cur_lru;
            end
        endcase
    end

    // Array writes: accepted updates and sweep clears (never concurrent)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(SETS); i++) begin
                lru_q[i] <= 3'd0;
                val_q[i] <= 4'd0;
                mod_q[i] <= 4'd0;
            end
        end else begin
            if (upd_write) begin
                lru_q[upd_idx] <= upd_lru_d;
                val_q[upd_idx] <= upd_val_d;
                mod_q[upd_idx] <= upd_mod_d;
            end
            if (sweep_active) begin
                lru_q[cnt_q] <= 3'd0;
                val_q[cnt_q] <= 4'd0;
                mod_q[cnt_q] <= 4'd0;
            end
        end
    end

    // Registered read with forwarding of same-edge sweep clear or update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_lru_q <= 3'd0;
            rd_val_q <= 4'd0;
            rd_mod_q <= 4'd0;
        end else if (rd_valid) begin
            if (sweep_active && (rd_idx == cnt_q)) begin
                rd_lru_q <= 3'd0;
                rd_val_q <= 4'd0;
                rd_mod_q <= 4'd0;
            end else if (upd_write && (rd_idx == upd_idx)) begin
                rd_lru_q <= upd_lru_d;
                rd_val_q <= upd_val_d;
                rd_mod_q <= upd_mod_d;
            end else begin
                rd_lru_q <= lru_q[rd_idx];
                rd_val_q <= val_q[rd_idx];
                rd_mod_q <= mod_q[rd_idx];
            end
        end
    end

    // Flush sweep FSM with registered busy/done and update-error pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= upd_fire && !way_onehot;
            case (state_q)
                ST_IDLE: begin
                    if (flush_req) begin
                        state_q <= ST_SWEEP;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    if (cnt_q == IDX_W'(SETS - 1)) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + IDX_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign lru_output_d = rd_lru_q;
    assign val_output_d = rd_val_q;
    assign mod_output_d = rd_mod_q;
    assign upd_ready    = !busy_q;
    assign upd_err      = err_q;
    assign flush_busy   = busy_q;
    assign flush_done   = done_q;

endmodule

// File: tb/tb_cache_state_update.sv
// Directed bench: instance A (8 sets) for flush behaviour, instance B (16 sets)
// for update/read behaviour including set 9. Both share the update/read inputs.
module tb_cache_state_update;

    logic       clk = 1'b0;
    logic       reset;
    logic       rd_valid;
    logic [3:0] rd_idx;
    logic       upd_valid;
    logic [3:0] upd_idx;
    logic [3:0] upd_way;
    logic [1:0] upd_op;
    logic       upd_dirty;
    logic       flush_req_a;

    logic [2:0] a_lru, b_lru;
    logic [3:0] a_val, b_val, a_mod, b_mod;
    logic       a_upd_ready, b_upd_ready, a_upd_err, b_upd_err;
    logic       a_flush_busy, b_flush_busy, a_flush_done, b_flush_done;

    int n_pass   = 0;
    int n_checks = 0;

    cache_state_update #(.SETS(8), .IDX_W(3)) u_dut_a (
        .clk(clk), .reset(reset),
        .rd_valid(rd_valid), .rd_idx(rd_idx[2:0]),
        .lru_output_d(a_lru), .val_output_d(a_val), .mod_output_d(a_mod),
        .upd_valid(upd_valid), .upd_ready(a_upd_ready), .upd_idx(upd_idx[2:0]),
        .upd_way(upd_way), .upd_op(upd_op), .upd_dirty(upd_dirty), .upd_err(a_upd_err),
        .flush_req(flush_req_a), .flush_busy(a_flush_busy), .flush_done(a_flush_done)
    );

    cache_state_update #(.SETS(16), .IDX_W(4)) u_dut_b (
        .clk(clk), .reset(reset),
        .rd_valid(rd_valid), .rd_idx(rd_idx),
        .lru_output_d(b_lru), .val_output_d(b_val), .mod_output_d(b_mod),
        .upd_valid(upd_valid), .upd_ready(b_upd_ready), .upd_idx(upd_idx),
        .upd_way(upd_way), .upd_op(upd_op), .upd_dirty(upd_dirty), .upd_err(b_upd_err),
        .flush_req(1'b0), .flush_busy(b_flush_busy), .flush_done(b_flush_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rd_valid    = 1'b0;
        rd_idx      = 4'd0;
        upd_valid   = 1'b0;
        upd_idx     = 4'd0;
        upd_way     = 4'd0;
        upd_op      = 2'b00;
        upd_dirty   = 1'b0;
        flush_req_a = 1'b0;
    endtask

    task automatic do_update(input logic [3:0] idx, input logic [3:0] way,
                             input logic [1:0] op, input logic dirty);
        upd_valid = 1'b1;
        upd_idx   = idx;
        upd_way   = way;
        upd_op    = op;
        upd_dirty = dirty;
        step();
        upd_valid = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] idx);
        rd_valid = 1'b1;
        rd_idx   = idx;
        step();
        rd_valid = 1'b0;
    endtask

    task automatic populate_a();
        for (int i = 0; i < 8; i++) begin
            do_update(4'(i), 4'(1 << (i % 4)), 2'b10, 1'(i % 2));
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        n_checks++;
        if ({b_upd_ready, b_flush_busy, b_flush_done, b_upd_err} !== 4'b1000)
            $display("FAIL reset_ctrl: got rdy/busy/done/err=%b expected 1000",
                     {b_upd_ready, b_flush_busy, b_flush_done, b_upd_err});
        else n_pass++;
        do_read(4'd5);
        n_checks++;
        if ({b_lru, b_val, b_mod} !== 11'd0)
            $display("FAIL reset_read5: got lru=%b val=%b mod=%b expected all 0", b_lru, b_val, b_mod);
        else n_pass++;
    endtask

    task automatic test_fills();
        logic [3:0] ways  [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        logic       dirty [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0] e_lru [4] = '{3'b110, 3'b100, 3'b001, 3'b000};
        logic [3:0] e_val [4] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
        logic [3:0] e_mod [4] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100};
        for (int i = 0; i < 4; i++) begin
            do_update(4'd3, ways[i], 2'b10, dirty[i]);
            do_read(4'd3);
            n_checks++;
            if ({b_lru, b_val, b_mod} !== {e_lru[i], e_val[i], e_mod[i]})
                $display("FAIL fill_%0d: got lru=%b val=%b mod=%b expected lru=%b val=%b mod=%b",
                         i, b_lru, b_val, b_mod, e_lru[i], e_val[i], e_mod[i]);
            else n_pass++;
        end
    endtask

    task automatic test_write_inval_bad();
        do_update(4'd3, 4'b0010, 2'b01, 1'b0);
        do_read(4'd3);
        n_checks++;
        if ({b_lru, b_val, b_mod} !== {3'b001, 4'b1111, 4'b0110})
            $display("FAIL write_hit: got lru=%b val=%b mod=%b expected lru=001 val=1111 mod=0110",
                     b_lru, b_val, b_mod);
        else n_pass++;
        do_update(4'd3, 4'b0100, 2'b11, 1'b0);
        do_read(4'd3);
        n_checks++;
        if ({b_lru, b_val, b_mod} !== {3'b001, 4'b1011, 4'b0010})
            $display("FAIL invalidate: got lru=%b val=%b mod=%b expected lru=001 val=1011 mod=0010",
                     b_lru, b_val, b_mod);
        else n_pass++;
        do_update(4'd3, 4'b0110, 2'b01, 1'b0);
        n_checks++;
        if (b_upd_err !== 1'b1) $display("FAIL bad_way_err: got %b expected 1", b_upd_err);
        else n_pass++;
        step();
        n_checks++;
        if (b_upd_err !== 1'b0) $display("FAIL bad_way_pulse: got %b expected 0", b_upd_err);
        else n_pass++;
        do_read(4'd3);
        n_checks++;
        if ({b_lru, b_val, b_mod} !== {3'b001, 4'b1011, 4'b0010})
            $display("FAIL bad_way_state: got lru=%b val=%b mod=%b expected lru=001 val=1011 mod=0010",
                     b_lru, b_val, b_mod);
        else n_pass++;
    endtask

    task automatic test_forwarding();
        rd_valid = 1'b1;
        rd_idx   = 4'd9;
        do_update(4'd9, 4'b0001, 2'b10, 1'b1);
        rd_valid = 1'b0;
        rd_idx   = 4'd3;
        n_checks++;
        if ({b_lru, b_val, b_mod} !== {3'b000, 4'b0001, 4'b0001})
            $display("FAIL forward: got lru=%b val=%b mod=%b expected lru=000 val=0001 mod=0001",
                     b_lru, b_val, b_mod);
        else n_pass++;
        step();
        n_checks++;
        if ({b_lru, b_val, b_mod} !== {3'b000, 4'b0001, 4'b0001})
            $display("FAIL read_hold: got lru=%b val=%b mod=%b expected lru=000 val=0001 mod=0001",
                     b_lru, b_val, b_mod);
        else n_pass++;
    endtask

    task automatic test_flush();
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at  = -1;
        int bad_rd   = 0;
        int bad_rdy  = 0;
        logic [3:0] e_val;
        populate_a();
        flush_req_a = 1'b1;
        rd_valid    = 1'b1;
        rd_idx      = 4'd7;
        step();
        flush_req_a = 1'b0;
        upd_valid   = 1'b1;
        upd_idx     = 4'd0;
        upd_way     = 4'b1000;
        upd_op      = 2'b10;
        upd_dirty   = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (a_flush_busy === 1'b1) begin
                busy_cnt++;
                if (a_upd_ready !== 1'b0) bad_rdy++;
            end
            if (a_flush_done === 1'b1) begin
                done_cnt++;
                done_at = k;
            end
            e_val = (k < 8) ? 4'b1000 : 4'b0000;
            if (a_val !== e_val) bad_rd++;
            if (k == 7) upd_valid = 1'b0;
            step();
        end
        rd_valid = 1'b0;
        n_checks++;
        if (busy_cnt != 8) $display("FAIL flush_busy_len: got %0d cycles expected 8", busy_cnt);
        else n_pass++;
        n_checks++;
        if (done_cnt != 1 || done_at != 8)
            $display("FAIL flush_done: got %0d pulses at cycle %0d expected 1 at cycle 8", done_cnt, done_at);
        else n_pass++;
        n_checks++;
        if (bad_rdy != 0) $display("FAIL flush_ready: got %0d busy cycles with ready=1 expected 0", bad_rdy);
        else n_pass++;
        n_checks++;
        if (bad_rd != 0) $display("FAIL flush_read7: got %0d wrong reads expected 0", bad_rd);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            do_read(4'(i));
            n_checks++;
            if ({a_lru, a_val, a_mod} !== 11'd0)
                $display("FAIL flush_clear_%0d: got lru=%b val=%b mod=%b expected all 0", i, a_lru, a_val, a_mod);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_sweep();
        int busy_cnt = 0;
        int done_cnt = 0;
        populate_a();
        flush_req_a = 1'b1;
        step();
        flush_req_a = 1'b0;
        step();
        step();
        step();
        n_checks++;
        if (a_flush_busy !== 1'b1) $display("FAIL abort_pre_busy: got %b expected 1", a_flush_busy);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({a_flush_busy, a_upd_ready, a_flush_done} !== 3'b010)
            $display("FAIL abort_async: got busy/rdy/done=%b expected 010",
                     {a_flush_busy, a_upd_ready, a_flush_done});
        else n_pass++;
        step();
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (a_flush_busy === 1'b1) busy_cnt++;
            if (a_flush_done === 1'b1) done_cnt++;
            step();
        end
        n_checks++;
        if (busy_cnt != 0 || done_cnt != 0)
            $display("FAIL abort_quiet: got busy=%0d done=%0d cycles expected 0 and 0", busy_cnt, done_cnt);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            do_read(4'(i));
            n_checks++;
            if ({a_lru, a_val, a_mod} !== 11'd0)
                $display("FAIL abort_clear_%0d: got lru=%b val=%b mod=%b expected all 0", i, a_lru, a_val, a_mod);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_fills();
        test_write_inval_bad();
        test_forwarding();
        test_flush();
        test_reset_mid_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
